// File: rtl/mc_ctrl.sv
// Main control FSM for the multi-cycle MIPS core.
// Moore outputs decoded from the state register (BRANCH pc_write follows zero);
// instruction fields are only consulted in DECODE and the states that select on them.
module mc_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [1:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXE_R    = 4'd2,
        S_WB_R     = 4'd3,
        S_EXE_I    = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_LW    = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    // Instruction classification used by DECODE; nop and illegal retire here.
    state_t dec_next;
    logic   dec_illegal;
    logic   dec_done;

    // Decode opcode/funct into the first execution state.
    always_comb begin
        dec_next    = S_FETCH;
        dec_illegal = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU, FN_SUBU: dec_next = S_EXE_R;
                    FN_JR:            dec_next = S_JUMP;
                    FN_SLL:           dec_next = S_FETCH;
                    default:          dec_illegal = 1'b1;
                endcase
            end
            OP_ORI, OP_LUI: dec_next = S_EXE_I;
            OP_LW, OP_SW:   dec_next = S_MEM_ADDR;
            OP_BEQ:         dec_next = S_BRANCH;
            OP_J, OP_JAL:   dec_next = S_JUMP;
            default:        dec_illegal = 1'b1;
        endcase
        if (dec_illegal)
            dec_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        dec_done = (dec_next == S_FETCH) || dec_illegal;
    end

    // Next-state and sticky illegal flag.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                state_d = dec_next;
                if (dec_illegal) illegal_d = 1'b1;
            end
            S_EXE_R:    state_d = S_WB_R;
            S_EXE_I:    state_d = S_WB_I;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_WB_LW;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // State and illegal flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Datapath controls per state; everything is held low while reset is asserted.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        ext_op     = 1'b0;
        alu_op     = ALU_ADD;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        pc_src     = 2'd0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'd1;
            end
            S_DECODE: begin
                alu_src_b  = 2'd3;
                ext_op     = 1'b1;
                instr_done = dec_done;
            end
            S_EXE_R: begin
                alu_src_a = 1'b1;
                alu_op    = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 2'd1;
                instr_done = 1'b1;
            end
            S_EXE_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = (opcode == OP_LUI) ? ALU_LUI : ALU_OR;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ext_op    = 1'b1;
            end
            S_WB_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = 2'd1;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                instr_done = 1'b1;
                if (opcode == OP_RTYPE) begin
                    pc_src = 2'd3;
                end else begin
                    pc_src = 2'd2;
                    if (opcode == OP_JAL) begin
                        // PC already holds PC+4 here, which is the link value.
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end
            end
            default: ;
        endcase
        if (!reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            ext_op     = 1'b0;
            alu_op     = ALU_ADD;
            reg_dst    = 2'd0;
            mem_to_reg = 2'd0;
            pc_src     = 2'd0;
            instr_done = 1'b0;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: two instances (no trap / trap) share the
// stimulus; each cycle the expected output vectors are queued and a monitor
// compares them on the falling edge.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;

    always #5 clk = ~clk;

    logic       pcw0, irw0, rw0, mw0, a0, ext0, done0, ill0;
    logic [1:0] b0, aop0, rd0, m2r0, pcs0;
    logic       pcw1, irw1, rw1, mw1, a1, ext1, done1, ill1;
    logic [1:0] b1, aop1, rd1, m2r1, pcs1;

    mc_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pcw0), .ir_write(irw0), .reg_write(rw0), .mem_write(mw0),
        .alu_src_a(a0), .alu_src_b(b0), .ext_op(ext0), .alu_op(aop0),
        .reg_dst(rd0), .mem_to_reg(m2r0), .pc_src(pcs0),
        .instr_done(done0), .illegal(ill0)
    );

    mc_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pcw1), .ir_write(irw1), .reg_write(rw1), .mem_write(mw1),
        .alu_src_a(a1), .alu_src_b(b1), .ext_op(ext1), .alu_op(aop1),
        .reg_dst(rd1), .mem_to_reg(m2r1), .pc_src(pcs1),
        .instr_done(done1), .illegal(ill1)
    );

    // [17]pcw [16]irw [15]rw [14]mw [13]a [12:11]b [10]ext [9:8]aop
    // [7:6]rd [5:4]m2r [3:2]pcs [1]done [0]illegal
    logic [17:0] act0, act1;
    assign act0 = {pcw0, irw0, rw0, mw0, a0, b0, ext0, aop0, rd0, m2r0, pcs0, done0, ill0};
    assign act1 = {pcw1, irw1, rw1, mw1, a1, b1, ext1, aop1, rd1, m2r1, pcs1, done1, ill1};

    typedef struct {
        string       name;
        logic [17:0] e0;
        logic [17:0] e1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic ill_e0 = 1'b0;
    logic ill_e1 = 1'b0;

    function automatic logic [17:0] ev(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic a, input logic [1:0] b,
                                       input logic ext, input logic [1:0] aop,
                                       input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic [1:0] pcs, input logic done);
        return {pcw, irw, rw, mw, a, b, ext, aop, rd, m2r, pcs, done, 1'b0};
    endfunction

    // Hand-derived per-state output vectors.
    localparam logic [17:0] E_ZERO  = 18'h0;
    logic [17:0] e_fetch, e_dec, e_dec_done, e_exe_addu, e_exe_subu, e_wb_r;
    logic [17:0] e_madr, e_mrd, e_wb_lw, e_mwr, e_exe_ori, e_exe_lui, e_wb_i;
    logic [17:0] e_beq_t, e_beq_f, e_j, e_jal, e_jr;
    initial begin
        e_fetch    = ev(1,1,0,0,0,2'd1,0,2'd0,2'd0,2'd0,2'd0,0);
        e_dec      = ev(0,0,0,0,0,2'd3,1,2'd0,2'd0,2'd0,2'd0,0);
        e_dec_done = ev(0,0,0,0,0,2'd3,1,2'd0,2'd0,2'd0,2'd0,1);
        e_exe_addu = ev(0,0,0,0,1,2'd0,0,2'd0,2'd0,2'd0,2'd0,0);
        e_exe_subu = ev(0,0,0,0,1,2'd0,0,2'd1,2'd0,2'd0,2'd0,0);
        e_wb_r     = ev(0,0,1,0,0,2'd0,0,2'd0,2'd1,2'd0,2'd0,1);
        e_madr     = ev(0,0,0,0,1,2'd2,1,2'd0,2'd0,2'd0,2'd0,0);
        e_mrd      = E_ZERO;
        e_wb_lw    = ev(0,0,1,0,0,2'd0,0,2'd0,2'd0,2'd1,2'd0,1);
        e_mwr      = ev(0,0,0,1,0,2'd0,0,2'd0,2'd0,2'd0,2'd0,1);
        e_exe_ori  = ev(0,0,0,0,1,2'd2,0,2'd2,2'd0,2'd0,2'd0,0);
        e_exe_lui  = ev(0,0,0,0,1,2'd2,0,2'd3,2'd0,2'd0,2'd0,0);
        e_wb_i     = ev(0,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0,1);
        e_beq_t    = ev(1,0,0,0,1,2'd0,0,2'd1,2'd0,2'd0,2'd1,1);
        e_beq_f    = ev(0,0,0,0,1,2'd0,0,2'd1,2'd0,2'd0,2'd1,1);
        e_j        = ev(1,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd2,1);
        e_jal      = ev(1,0,1,0,0,2'd0,0,2'd0,2'd2,2'd2,2'd2,1);
        e_jr       = ev(1,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd3,1);
    end

    // Monitor: outputs are always presented, so one queued entry is checked per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (act0 !== e.e0) begin
                errors++;
                $display("FAIL %s trap0: got %05h want %05h", e.name, act0, e.e0);
            end
            checks++;
            if (act1 !== e.e1) begin
                errors++;
                $display("FAIL %s trap1: got %05h want %05h", e.name, act1, e.e1);
            end
        end
    end

    // Queue this cycle's expectation, then move to just after the next rising edge.
    task automatic cyc2(input string nm, input logic [17:0] x0, input logic [17:0] x1);
        exp_t e;
        e.name = nm;
        e.e0   = x0 | {17'b0, ill_e0};
        e.e1   = x1 | {17'b0, ill_e1};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic [17:0] x);
        cyc2(nm, x, x);
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc("rst0", E_ZERO);
        cyc("rst1", E_ZERO);
        reset = 1'b1;

        // addu $3,$1,$2
        instr(6'h00, 6'h21);
        cyc("addu_f", e_fetch);
        cyc("addu_d", e_dec);
        cyc("addu_ex", e_exe_addu);
        cyc("addu_wb", e_wb_r);
        // subu
        instr(6'h00, 6'h23);
        cyc("subu_f", e_fetch);
        cyc("subu_d", e_dec);
        cyc("subu_ex", e_exe_subu);
        cyc("subu_wb", e_wb_r);
        // lw then sw
        instr(6'h23, 6'h04);
        cyc("lw_f", e_fetch);
        cyc("lw_d", e_dec);
        cyc("lw_addr", e_madr);
        cyc("lw_rd", e_mrd);
        cyc("lw_wb", e_wb_lw);
        instr(6'h2B, 6'h08);
        cyc("sw_f", e_fetch);
        cyc("sw_d", e_dec);
        cyc("sw_addr", e_madr);
        cyc("sw_wr", e_mwr);
        // ori, lui
        instr(6'h0D, 6'h10);
        cyc("ori_f", e_fetch);
        cyc("ori_d", e_dec);
        cyc("ori_ex", e_exe_ori);
        cyc("ori_wb", e_wb_i);
        instr(6'h0F, 6'h00);
        cyc("lui_f", e_fetch);
        cyc("lui_d", e_dec);
        cyc("lui_ex", e_exe_lui);
        cyc("lui_wb", e_wb_i);
        // beq taken / not taken
        instr(6'h04, 6'h03);
        zero = 1'b1;
        cyc("beqt_f", e_fetch);
        cyc("beqt_d", e_dec);
        cyc("beqt_br", e_beq_t);
        zero = 1'b0;
        cyc("beqn_f", e_fetch);
        cyc("beqn_d", e_dec);
        cyc("beqn_br", e_beq_f);
        // j, jal, jr, nop
        instr(6'h02, 6'h10);
        cyc("j_f", e_fetch);
        cyc("j_d", e_dec);
        cyc("j_jmp", e_j);
        instr(6'h03, 6'h10);
        cyc("jal_f", e_fetch);
        cyc("jal_d", e_dec);
        cyc("jal_jmp", e_jal);
        instr(6'h00, 6'h08);
        cyc("jr_f", e_fetch);
        cyc("jr_d", e_dec);
        cyc("jr_jmp", e_jr);
        instr(6'h00, 6'h00);
        cyc("nop_f", e_fetch);
        cyc("nop_d", e_dec_done);
        // reset in the middle of an addu
        instr(6'h00, 6'h21);
        cyc("mid_f", e_fetch);
        cyc("mid_d", e_dec);
        reset = 1'b0;
        cyc("mid_rst0", E_ZERO);
        cyc("mid_rst1", E_ZERO);
        cyc("mid_rst2", E_ZERO);
        reset = 1'b1;
        cyc("mid_f2", e_fetch);
        cyc("mid_d2", e_dec);
        cyc("mid_ex", e_exe_addu);
        cyc("mid_wb", e_wb_r);
        // illegal opcode: retires from DECODE, flag visible from the next cycle
        instr(6'h3F, 6'h00);
        cyc("ill_f", e_fetch);
        cyc("ill_d", e_dec_done);
        ill_e0 = 1'b1;
        ill_e1 = 1'b1;
        instr(6'h00, 6'h00);
        cyc2("ill_next_f", e_fetch, E_ZERO);
        cyc2("ill_next_d", e_dec_done, E_ZERO);
        cyc2("ill_halt", e_fetch, E_ZERO);
        cyc2("ill_halt2", e_dec_done, E_ZERO);
        // reset clears the flag and the trap
        reset = 1'b0;
        ill_e0 = 1'b0;
        ill_e1 = 1'b0;
        cyc("clr_rst", E_ZERO);
        reset = 1'b1;
        instr(6'h00, 6'h21);
        cyc("clr_f", e_fetch);
        cyc("clr_d", e_dec);
        cyc("clr_ex", e_exe_addu);

        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d entries left, want 0", exp_q.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
